// File: rtl/ttt_pkg.sv
// Shared types and width helpers for the ttt network scheduler.
package ttt_pkg;

  localparam int unsigned TOKEN_W = 4;

  typedef logic signed [TOKEN_W-1:0] token_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    ACK  = 2'd3
  } sched_state_t;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ttt_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after rr_ptr, wrapping.
module ttt_rr_arbiter #(
  parameter int unsigned NUM_REQ = 10,
  parameter int unsigned PID_W   = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PID_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PID_W-1:0]   gnt_idx,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ttt_network_scheduler.sv
// Round-robin scheduler walking per-processor connection lists of the ttt network.
// Optional event counter on stat_events when TTT_SCHED_STATS_EN is defined.
module ttt_network_scheduler
  import ttt_pkg::*;
#(
  parameter int unsigned NUM_PROCESSORS  = 10,
  parameter int unsigned NUM_CONNECTIONS = 50,
  parameter int unsigned NEW_TOKEN_BITS  = 4,
  parameter int unsigned PID_W           = id_width(NUM_PROCESSORS),
  parameter int unsigned CID_W           = id_width(NUM_CONNECTIONS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             halt,
  input  logic [NUM_PROCESSORS-1:0]        fire_req,
  output logic [NUM_PROCESSORS-1:0]        fire_ack,
  output logic                             busy,
  output logic [PID_W-1:0]                 net_processor_id,
  output logic [CID_W-1:0]                 net_connection_id,
  input  logic                             net_done,
  input  logic                             net_valid,
  input  logic [PID_W-1:0]                 net_target_id,
  input  logic signed [NEW_TOKEN_BITS-1:0] net_new_good_tokens,
  input  logic signed [NEW_TOKEN_BITS-1:0] net_new_bad_tokens,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PID_W-1:0]                 out_target_id,
  output logic signed [NEW_TOKEN_BITS-1:0] out_good_tokens,
  output logic signed [NEW_TOKEN_BITS-1:0] out_bad_tokens
`ifdef TTT_SCHED_STATS_EN
  ,
  output logic [15:0]                      stat_events
`endif
);

  localparam logic [CID_W-1:0] CidLast = CID_W'(NUM_CONNECTIONS - 1);
  localparam logic [PID_W-1:0] PidLast = PID_W'(NUM_PROCESSORS - 1);

  sched_state_t              state_q;
  logic [PID_W-1:0]          rr_ptr_q;
  logic [NUM_PROCESSORS-1:0] gnt;
  logic [PID_W-1:0]          gnt_idx;
  logic                      gnt_any;

  ttt_rr_arbiter #(
    .NUM_REQ (NUM_PROCESSORS),
    .PID_W   (PID_W)
  ) u_arb (
    .req     (fire_req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      rr_ptr_q          <= '0;
      net_processor_id  <= '0;
      net_connection_id <= '0;
      out_target_id     <= '0;
      out_good_tokens   <= '0;
      out_bad_tokens    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!halt && gnt_any) begin
            net_processor_id  <= gnt_idx;
            net_connection_id <= '0;
            state_q           <= SCAN;
          end
        end
        SCAN: begin
          if (net_done) begin
            state_q <= ACK;
          end else if (net_valid) begin
            out_target_id   <= net_target_id;
            out_good_tokens <= net_new_good_tokens;
            out_bad_tokens  <= net_new_bad_tokens;
            state_q         <= EMIT;
          end else if (net_connection_id != CidLast) begin
            net_connection_id <= net_connection_id + 1'b1;
          end else begin
            // End of connection memory without a done marker: stop, never wrap.
            state_q <= ACK;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (net_connection_id == CidLast) begin
              state_q <= ACK;
            end else begin
              net_connection_id <= net_connection_id + 1'b1;
              state_q           <= SCAN;
            end
          end
        end
        ACK: begin
          rr_ptr_q <= (net_processor_id == PidLast) ? '0 : net_processor_id + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    fire_ack = '0;
    if (state_q == ACK) fire_ack[net_processor_id] = 1'b1;
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);

`ifdef TTT_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_events <= '0;
    end else if (out_valid && out_ready && (stat_events != 16'hFFFF)) begin
      stat_events <= stat_events + 16'd1;
    end
  end
`endif

endmodule
